// File: rtl/math_pkg.sv
// Shared sizing helpers for width and word-count derivation.
package math_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of word_w-bit words needed to carry size bits.
  function automatic int unsigned get_word_count_for_size(input int unsigned size,
                                                          input int unsigned word_w);
    return (size + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/msg_word_deserializer_pkg.sv
// Types shared by the message word deserializer and its splitter-side peers.
package msg_word_deserializer_pkg;

  typedef enum logic {
    COLLECT,
    HOLD
  } deser_state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX index counter with increment, clear and a wrap flag (count == MAX-1).
module mod_counter
  import math_pkg::*;
#(
  parameter int unsigned MAX = 4,
  localparam int unsigned W = (clog2(MAX) > 1) ? clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == W'(MAX - 1));

  // Clear wins over increment; increment at the last value wraps to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msg_word_deserializer.sv
// Reassembles LSW-first WORD_W-bit words into one MSG_W-bit message (valid/ready both sides).
// Optional build macro MSG_DESER_LAST_CHECK_EN: checks s_last framing, closes short messages
// early with zero fill and raises a sticky m_err.
module msg_word_deserializer
  import math_pkg::*;
  import msg_word_deserializer_pkg::*;
#(
  parameter int unsigned MSG_W  = 64,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [MSG_W-1:0]  m_data,
  output logic              m_err
);

  localparam int unsigned WORDS = get_word_count_for_size(MSG_W, WORD_W);
  localparam int unsigned IDX_W = (clog2(WORDS) > 1) ? clog2(WORDS) : 1;

  deser_state_t     state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx;
  logic             idx_wrap;
  logic             idx_inc;
  logic             idx_clr;
  logic             accept;
  logic             early_last;

`ifndef MSG_DESER_LAST_CHECK_EN
  logic unused_last;
  assign unused_last = s_last;
`endif

  mod_counter #(.MAX(WORDS)) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (idx_inc),
    .clr_i  (idx_clr),
    .cnt_o  (idx),
    .wrap_o (idx_wrap)
  );

  // In HOLD the consumer's ready passes straight through so word 0 of the next
  // message can be taken in the same cycle the current message is consumed.
  assign s_ready = (state_q == COLLECT) ? 1'b1 : m_ready;
  assign accept  = s_valid && s_ready;
  assign m_valid = (state_q == HOLD);
  assign m_data  = msg_q;
  assign m_err   = err_q;

  // Next state: word capture into the message buffer, index control and framing check.
  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    err_d      = err_q;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    early_last = 1'b0;
`ifdef MSG_DESER_LAST_CHECK_EN
    if (accept) begin
      if (s_last && !idx_wrap) begin
        early_last = 1'b1;
        err_d      = 1'b1;
      end
      if (!s_last && idx_wrap) begin
        err_d = 1'b1;
      end
    end
`endif
    if (accept) begin
      // Bit-wise walk so the final partial word drops its bits above MSG_W.
      for (int unsigned i = 0; i < MSG_W; i++) begin
        if (IDX_W'(i / WORD_W) == idx) begin
          msg_d[i] = s_data[i % WORD_W];
        end else if (early_last && (IDX_W'(i / WORD_W) > idx)) begin
          msg_d[i] = 1'b0;
        end
      end
      if (early_last) begin
        idx_clr = 1'b1;
      end else begin
        idx_inc = 1'b1;
      end
      state_d = (idx_wrap || early_last) ? HOLD : COLLECT;
    end else if ((state_q == HOLD) && m_ready) begin
      state_d = COLLECT;
    end
  end

  // State, message buffer and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      msg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      err_q   <= err_d;
    end
  end

endmodule
